wb_pio_arbiter: RTL and testbench

WB_PIO_ARBITER -- requirements
Module: wb_pio_arbiter

---
 rtl/wb_pio_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_wb_pio_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pio_arbiter.sv
// Two-master Wishbone arbiter in front of a single PIO slave, round-robin on ties.
// Optional bus watchdog enabled by defining WB_PIO_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module wb_pio_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_dat_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_dat_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    localparam logic [31:0] ABORT_DAT = 32'hDEAD_BEEF;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    // last granted master: 0 = m0, 1 = m1
    logic   last_q, last_d;
    logic   req0, req1;
    logic   abort;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    // Ownership state and round-robin history
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Arbitration: grant from IDLE only, release when owner drops cyc
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant is a pure decode of the state register
    always_comb begin
        unique case (state_q)
            OWN0:    grant_o = 2'b01;
            OWN1:    grant_o = 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

`ifdef WB_PIO_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
    logic       own_stb;

    // Owner's strobe as seen before any abort masking
    assign own_stb = ((state_q == OWN0) & m0_stb_i)
                   | ((state_q == OWN1) & m1_stb_i);

    // Abort on the TIMEOUT_CYCLES-th consecutive stalled cycle
    assign abort = own_stb & ~s_ack_i & ~wb_rst_i & (cnt_q == TO_LAST);

    // Watchdog next-state: count stalls, clear on ack, idle strobe or abort
    always_comb begin
        cnt_d     = 8'd0;
        timeout_d = timeout_q | abort;
        if (!abort && own_stb && !s_ack_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Watchdog registers; the sticky flag only clears on reset
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign abort     = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Combinational routing between owner and slave, all quiet in reset
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = 4'd0;
        s_adr_o  = 32'd0;
        s_dat_o  = 32'd0;
        m0_ack_o = 1'b0;
        m0_dat_o = 32'd0;
        m1_ack_o = 1'b0;
        m1_dat_o = 32'd0;
        if (!wb_rst_i) begin
            unique case (state_q)
                OWN0: begin
                    s_cyc_o  = m0_cyc_i & ~abort;
                    s_stb_o  = m0_stb_i & ~abort;
                    s_we_o   = m0_we_i;
                    s_sel_o  = m0_sel_i;
                    s_adr_o  = m0_adr_i;
                    s_dat_o  = m0_dat_i;
                    m0_ack_o = s_ack_i | abort;
                    m0_dat_o = abort ? ABORT_DAT : s_dat_i;
                end
                OWN1: begin
                    s_cyc_o  = m1_cyc_i & ~abort;
                    s_stb_o  = m1_stb_i & ~abort;
                    s_we_o   = m1_we_i;
                    s_sel_o  = m1_sel_i;
                    s_adr_o  = m1_adr_i;
                    s_dat_o  = m1_dat_i;
                    m1_ack_o = s_ack_i | abort;
                    m1_dat_o = abort ? ABORT_DAT : s_dat_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_pio_arbiter.sv
// Directed self-checking bench for wb_pio_arbiter.
// Watchdog scenario follows WB_PIO_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_wb_pio_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_cyc, m0_stb, m0_we;
    logic [3:0]  m0_sel;
    logic [31:0] m0_adr, m0_wdat;
    logic        m0_ack;
    logic [31:0] m0_rdat;
    logic        m1_cyc, m1_stb, m1_we;
    logic [3:0]  m1_sel;
    logic [31:0] m1_adr, m1_wdat;
    logic        m1_ack;
    logic [31:0] m1_rdat;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wdat;
    logic        s_ack;
    logic [31:0] s_rdat;
    logic [1:0]  grant;
    logic        tmo;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_pio_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
        .m0_sel_i(m0_sel), .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat),
        .m0_ack_o(m0_ack), .m0_dat_o(m0_rdat),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
        .m1_sel_i(m1_sel), .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat),
        .m1_ack_o(m1_ack), .m1_dat_o(m1_rdat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_sel_o(s_sel), .s_adr_o(s_adr), .s_dat_o(s_wdat),
        .s_ack_i(s_ack), .s_dat_i(s_rdat),
        .grant_o(grant), .timeout_o(tmo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 0;
        m0_adr = 0; m0_wdat = 0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 0;
        m1_adr = 0; m1_wdat = 0;
        s_ack = 0; s_rdat = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL reset_grant got=%b exp=00", grant);
        end
        checks++;
        if (tmo !== 1'b0) begin
            failures++;
            $display("FAIL reset_timeout got=%b exp=0", tmo);
        end
        checks++;
        if ({s_cyc, s_stb, s_adr} !== 34'd0) begin
            failures++;
            $display("FAIL reset_s_out got=%h exp=0", {s_cyc, s_stb, s_adr});
        end
        rst = 0;
    endtask

    task automatic test_single_write();
        int acks;
        acks = 0;
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF;
        m0_adr = 32'h3000_0004; m0_wdat = 32'h1234_5678;
        #1;
        checks++;
        if (grant !== 2'b00 || s_cyc !== 1'b0) begin
            failures++;
            $display("FAIL wr_pre_grant got=%b/%b exp=00/0", grant, s_cyc);
        end
        tick();
        checks++;
        if (grant !== 2'b01) begin
            failures++;
            $display("FAIL wr_grant got=%b exp=01", grant);
        end
        checks++;
        if (s_cyc !== 1 || s_we !== 1 || s_adr !== 32'h3000_0004
            || s_wdat !== 32'h1234_5678 || s_sel !== 4'hF) begin
            failures++;
            $display("FAIL wr_s_bus got=%b%b %h %h %h", s_cyc, s_we,
                     s_adr, s_wdat, s_sel);
        end
        for (int i = 0; i < 3; i++) begin
            s_ack = (i == 2);
            #1;
            if (m0_ack === 1'b1) acks++;
            tick();
        end
        s_ack = 0;
        m0_cyc = 0; m0_stb = 0;
        #1;
        if (m0_ack === 1'b1) acks++;
        checks++;
        if (acks !== 1) begin
            failures++;
            $display("FAIL wr_ack_count got=%0d exp=1", acks);
        end
        checks++;
        if (grant !== 2'b01 || s_cyc !== 1'b0) begin
            failures++;
            $display("FAIL wr_drop got=%b/%b exp=01/0", grant, s_cyc);
        end
        tick();
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL wr_release got=%b exp=00", grant);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        m0_cyc = 1; m0_stb = 1;
        m1_cyc = 1; m1_stb = 1;
        tick();
        checks++;
        if (grant !== 2'b01) begin
            failures++;
            $display("FAIL rr_first got=%b exp=01", grant);
        end
        m0_cyc = 0; m0_stb = 0;
        tick();
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL rr_gap got=%b exp=00", grant);
        end
        tick();
        checks++;
        if (grant !== 2'b10) begin
            failures++;
            $display("FAIL rr_second got=%b exp=10", grant);
        end
        m0_cyc = 1; m0_stb = 1;
        tick();
        checks++;
        if (grant !== 2'b10 || m0_ack !== 1'b0) begin
            failures++;
            $display("FAIL rr_no_preempt got=%b/%b exp=10/0", grant, m0_ack);
        end
        m1_cyc = 0; m1_stb = 0;
        tick();
        m1_cyc = 1; m1_stb = 1;
        #1;
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL rr_gap2 got=%b exp=00", grant);
        end
        tick();
        checks++;
        if (grant !== 2'b01) begin
            failures++;
            $display("FAIL rr_tie2 got=%b exp=01", grant);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_read_m1();
        int bad;
        bad = 0;
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h3000_0010;
        tick();
        m0_cyc = 1; m0_stb = 1;
        checks++;
        if (grant !== 2'b10) begin
            failures++;
            $display("FAIL rd_grant got=%b exp=10", grant);
        end
        s_rdat = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            s_ack = (i == 1);
            #1;
            if (m0_ack !== 1'b0 || m0_rdat !== 32'd0) bad++;
            if (i == 1) begin
                checks++;
                if (m1_ack !== 1'b1 || m1_rdat !== 32'hCAFE_F00D) begin
                    failures++;
                    $display("FAIL rd_m1_data got=%b %h exp=1 cafef00d",
                             m1_ack, m1_rdat);
                end
            end
            tick();
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL rd_m0_quiet got=%0d exp=0", bad);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_burst();
        int acks;
        int bad;
        acks = 0;
        bad = 0;
        do_reset();
        m0_cyc = 1; m0_stb = 1;
        m1_cyc = 1; m1_stb = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            m0_stb = (i != 2);
            s_ack = (i != 2);
            s_rdat = 32'h100 + i;
            m0_adr = 32'h3000_0000 + 4 * i;
            #1;
            if (m0_ack === 1'b1 && m0_rdat === 32'h100 + i) acks++;
            if (grant !== 2'b01 || m1_ack !== 1'b0) bad++;
            if (i == 2 && s_stb !== 1'b0) bad++;
            tick();
        end
        s_ack = 0;
        checks++;
        if (acks !== 4) begin
            failures++;
            $display("FAIL burst_acks got=%0d exp=4", acks);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL burst_owner got=%0d exp=0", bad);
        end
        m0_cyc = 0; m0_stb = 0;
        tick();
        tick();
        checks++;
        if (grant !== 2'b10) begin
            failures++;
            $display("FAIL burst_handoff got=%b exp=10", grant);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int acks;
        acks = 0;
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h3000_0020;
        tick();
`ifdef WB_PIO_ARB_TIMEOUT_EN
        for (int i = 1; i <= TO; i++) begin
            #1;
            if (i < TO && m0_ack === 1'b1) acks++;
            if (i == TO) begin
                checks++;
                if (m0_ack !== 1'b1 || m0_rdat !== 32'hDEAD_BEEF) begin
                    failures++;
                    $display("FAIL to_abort got=%b %h exp=1 deadbeef",
                             m0_ack, m0_rdat);
                end
                checks++;
                if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin
                    failures++;
                    $display("FAIL to_force_low got=%b%b exp=00",
                             s_cyc, s_stb);
                end
            end
            tick();
        end
        checks++;
        if (acks !== 0) begin
            failures++;
            $display("FAIL to_early_ack got=%0d exp=0", acks);
        end
        checks++;
        if (tmo !== 1'b1 || grant !== 2'b01) begin
            failures++;
            $display("FAIL to_flag got=%b/%b exp=1/01", tmo, grant);
        end
        m0_cyc = 0; m0_stb = 0;
        tick();
        tick();
        tick();
        checks++;
        if (tmo !== 1'b1) begin
            failures++;
            $display("FAIL to_sticky got=%b exp=1", tmo);
        end
        do_reset();
        checks++;
        if (tmo !== 1'b0) begin
            failures++;
            $display("FAIL to_reset_clear got=%b exp=0", tmo);
        end
`else
        for (int i = 0; i < 1000; i++) begin
            if (m0_ack === 1'b1 || tmo !== 1'b0 || grant !== 2'b01) acks++;
            tick();
        end
        checks++;
        if (acks !== 0) begin
            failures++;
            $display("FAIL hang_stall got=%0d exp=0", acks);
        end
        checks++;
        if (s_cyc !== 1'b1 || s_stb !== 1'b1) begin
            failures++;
            $display("FAIL hang_bus got=%b%b exp=11", s_cyc, s_stb);
        end
        clear_inputs();
        tick();
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_we = 1;
        m1_adr = 32'h3000_0008; m1_wdat = 32'h5555_AAAA;
        tick();
        checks++;
        if (grant !== 2'b10) begin
            failures++;
            $display("FAIL rm_grant got=%b exp=10", grant);
        end
        s_ack = 1;
        rst = 1;
        #1;
        checks++;
        if (m1_ack !== 1'b0) begin
            failures++;
            $display("FAIL rm_ack got=%b exp=0", m1_ack);
        end
        checks++;
        if ({s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat} !== 71'd0) begin
            failures++;
            $display("FAIL rm_s_out got=%h exp=0",
                     {s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat});
        end
        tick();
        checks++;
        if (grant !== 2'b00 || m1_ack !== 1'b0) begin
            failures++;
            $display("FAIL rm_drop got=%b/%b exp=00/0", grant, m1_ack);
        end
        rst = 0;
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_write();
        test_round_robin();
        test_read_m1();
        test_burst();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
